// File: rtl/pulse_cmd_loader.sv
// pulse_cmd_loader: parses framed host write commands from the UART receiver
// into shadow copies of the pulse-timing parameters. A commit command copies
// every shadow into the active registers in a single cycle, so the sequencer
// never runs on a half-updated parameter set. Each frame gets an ACK/NAK byte.
module pulse_cmd_loader #(
    parameter int unsigned TIMEOUT  = 1200000,
    parameter logic [23:0] D_PERIOD = 24'h010000,
    parameter logic [15:0] D_P1W    = 16'd30,
    parameter logic [15:0] D_DEL    = 16'd200,
    parameter logic [15:0] D_P2W    = 16'd60,
    parameter logic [15:0] D_NUTD   = 16'd100,
    parameter logic [7:0]  D_NUTW   = 8'd100,
    parameter logic [7:0]  D_BLK    = 8'd50,
    parameter logic [15:0] D_BLKOFF = 16'd100,
    parameter logic [7:0]  D_CPMG   = 8'd1,
    parameter logic [2:0]  D_FLAGS  = 3'b111
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic [23:0] period,
    output logic [15:0] p1width,
    output logic [15:0] delay,
    output logic [15:0] p2width,
    output logic [15:0] nut_del,
    output logic [15:0] pulse_block_off,
    output logic [7:0]  nut_wid,
    output logic [7:0]  pulse_block,
    output logic [7:0]  cpmg,
    output logic        pump,
    output logic        block,
    output logic        nutation,
    output logic        rx_done,
    output logic        err
);

    // One complete parameter set; used for both the shadow and active copies.
    typedef struct packed {
        logic [23:0] period;
        logic [15:0] p1width;
        logic [15:0] delay;
        logic [15:0] p2width;
        logic [15:0] nut_del;
        logic [15:0] pulse_block_off;
        logic [7:0]  nut_wid;
        logic [7:0]  pulse_block;
        logic [7:0]  cpmg;
        logic        nutation;
        logic        block;
        logic        pump;
    } params_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_EXEC,
        S_RESP
    } state_t;

    localparam params_t DEFAULTS = '{
        period:          D_PERIOD,
        p1width:         D_P1W,
        delay:           D_DEL,
        p2width:         D_P2W,
        nut_del:         D_NUTD,
        pulse_block_off: D_BLKOFF,
        nut_wid:         D_NUTW,
        pulse_block:     D_BLK,
        cpmg:            D_CPMG,
        nutation:        D_FLAGS[2],
        block:           D_FLAGS[1],
        pump:            D_FLAGS[0]
    };

    localparam int unsigned    TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    localparam logic [7:0] CMD_PERIOD = 8'h01;
    localparam logic [7:0] CMD_P1W    = 8'h02;
    localparam logic [7:0] CMD_DEL    = 8'h03;
    localparam logic [7:0] CMD_P2W    = 8'h04;
    localparam logic [7:0] CMD_NUTD   = 8'h05;
    localparam logic [7:0] CMD_NUTW   = 8'h06;
    localparam logic [7:0] CMD_FLAGS  = 8'h07;
    localparam logic [7:0] CMD_BLK    = 8'h08;
    localparam logic [7:0] CMD_BLKOFF = 8'h09;
    localparam logic [7:0] CMD_CPMG   = 8'h0A;
    localparam logic [7:0] CMD_COMMIT = 8'h0F;

    localparam logic [7:0] RESP_ACK = 8'h06;
    localparam logic [7:0] RESP_NAK = 8'h15;

    // Number of data bytes following a command; 0 for commit and unknown bytes.
    function automatic logic [1:0] data_len(input logic [7:0] cmd);
        case (cmd)
            CMD_PERIOD:                                       data_len = 2'd3;
            CMD_P1W, CMD_DEL, CMD_P2W, CMD_NUTD, CMD_BLKOFF:  data_len = 2'd2;
            CMD_NUTW, CMD_FLAGS, CMD_BLK, CMD_CPMG:           data_len = 2'd1;
            default:                                          data_len = 2'd0;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_cmd;
    logic [23:0]      r_asm;
    logic [1:0]       r_cnt;
    logic [TMO_W-1:0] r_tmo;
    params_t          r_shadow;
    params_t          r_active;
    logic             r_tx_valid;
    logic [7:0]       r_tx_byte;
    logic             r_rx_done;
    logic             r_err;

    logic w_latch_cmd;
    logic w_shift;
    logic w_wr_shadow;
    logic w_commit;
    logic w_tx_set;
    logic w_nak;
    logic w_tx_done;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state and per-cycle control strobes for the frame parser.
    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_latch_cmd  = 1'b0;
        w_shift      = 1'b0;
        w_wr_shadow  = 1'b0;
        w_commit     = 1'b0;
        w_tx_set     = 1'b0;
        w_nak        = 1'b0;
        w_tx_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_latch_cmd = 1'b1;
                    if (data_len(rx_byte) != 2'd0) begin
                        w_next_state = S_DATA;
                    end else if (rx_byte == CMD_COMMIT) begin
                        w_next_state = S_EXEC;
                    end else begin
                        w_next_state = S_RESP;
                        w_tx_set     = 1'b1;
                        w_nak        = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // Timeout is checked first: a byte arriving on the expiry cycle is dropped.
                if (r_tmo == TMO_MAX) begin
                    w_next_state = S_RESP;
                    w_tx_set     = 1'b1;
                    w_nak        = 1'b1;
                end else if (r_cnt == 2'd0) begin
                    w_wr_shadow  = 1'b1;
                    w_next_state = S_RESP;
                    w_tx_set     = 1'b1;
                end else if (rx_valid) begin
                    w_shift = 1'b1;
                end
            end
            S_EXEC: begin
                w_commit     = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (r_tx_valid && tx_ready) begin
                    w_tx_done    = 1'b1;
                    w_next_state = S_IDLE;
                end else if (!r_tx_valid) begin
                    // Arrived from EXEC: raise the ACK one cycle after the commit.
                    w_tx_set = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Command latch, MSB-first byte assembly, remaining-byte count and idle timeout.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cmd <= '0;
            r_asm <= '0;
            r_cnt <= '0;
            r_tmo <= '0;
        end else if (w_latch_cmd) begin
            r_cmd <= rx_byte;
            r_cnt <= data_len(rx_byte);
            r_tmo <= '0;
        end else if (w_shift) begin
            r_asm <= {r_asm[15:0], rx_byte};
            r_cnt <= r_cnt - 2'd1;
            r_tmo <= '0;
        end else if (r_state == S_DATA) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    // Shadow parameter set, written once per completed data frame.
    // NOTE: these are flop banks rather than RAM, so they are reset to defaults
    // and a reset mid-frame cannot leave a partial write behind.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shadow <= DEFAULTS;
        end else if (w_wr_shadow) begin
            case (r_cmd)
                CMD_PERIOD: r_shadow.period          <= r_asm;
                CMD_P1W:    r_shadow.p1width         <= r_asm[15:0];
                CMD_DEL:    r_shadow.delay           <= r_asm[15:0];
                CMD_P2W:    r_shadow.p2width         <= r_asm[15:0];
                CMD_NUTD:   r_shadow.nut_del         <= r_asm[15:0];
                CMD_BLKOFF: r_shadow.pulse_block_off <= r_asm[15:0];
                CMD_NUTW:   r_shadow.nut_wid         <= r_asm[7:0];
                CMD_BLK:    r_shadow.pulse_block     <= r_asm[7:0];
                CMD_CPMG:   r_shadow.cpmg            <= r_asm[7:0];
                CMD_FLAGS: begin
                    r_shadow.nutation <= r_asm[2];
                    r_shadow.block    <= r_asm[1];
                    r_shadow.pump     <= r_asm[0];
                end
                default: ;
            endcase
        end
    end

    // Active parameter set and the commit strobe, updated together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_active  <= DEFAULTS;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_done <= w_commit;
            if (w_commit) r_active <= r_shadow;
        end
    end

    // Response byte, held with tx_valid until the transmitter takes it; err marks a NAK's first cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_tx_set & w_nak;
            if (w_tx_done) begin
                r_tx_valid <= 1'b0;
            end else if (w_tx_set) begin
                r_tx_valid <= 1'b1;
                r_tx_byte  <= w_nak ? RESP_NAK : RESP_ACK;
            end
        end
    end

    assign tx_valid        = r_tx_valid;
    assign tx_byte         = r_tx_byte;
    assign rx_done         = r_rx_done;
    assign err             = r_err;
    assign period          = r_active.period;
    assign p1width         = r_active.p1width;
    assign delay           = r_active.delay;
    assign p2width         = r_active.p2width;
    assign nut_del         = r_active.nut_del;
    assign pulse_block_off = r_active.pulse_block_off;
    assign nut_wid         = r_active.nut_wid;
    assign pulse_block     = r_active.pulse_block;
    assign cpmg            = r_active.cpmg;
    assign nutation        = r_active.nutation;
    assign block           = r_active.block;
    assign pump            = r_active.pump;

endmodule

// File: tb/tb_pulse_cmd_loader.sv
// Bench for pulse_cmd_loader: directed frame scenarios plus random frame
// streams, compared against a per-command table model of shadow/active values.
module tb_pulse_cmd_loader;

    localparam int TMO = 64;

    logic        clk;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic [23:0] period;
    logic [15:0] p1width, delay, p2width, nut_del, pulse_block_off;
    logic [7:0]  nut_wid, pulse_block, cpmg;
    logic        pump, block, nutation;
    logic        rx_done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model tables indexed by command byte 1..10.
    int          len_tab  [1:10] = '{3, 2, 2, 2, 2, 1, 1, 1, 2, 1};
    int          wid_tab  [1:10] = '{24, 16, 16, 16, 16, 8, 3, 8, 16, 8};
    logic [23:0] dflt_tab [1:10] = '{24'h010000, 24'd30, 24'd200, 24'd60, 24'd100,
                                     24'd100, 24'd7, 24'd50, 24'd100, 24'd1};
    logic [23:0] exp_shadow [1:10];
    logic [23:0] exp_active [1:10];

    pulse_cmd_loader #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .rx_valid        (rx_valid),
        .rx_byte         (rx_byte),
        .tx_ready        (tx_ready),
        .tx_valid        (tx_valid),
        .tx_byte         (tx_byte),
        .period          (period),
        .p1width         (p1width),
        .delay           (delay),
        .p2width         (p2width),
        .nut_del         (nut_del),
        .pulse_block_off (pulse_block_off),
        .nut_wid         (nut_wid),
        .pulse_block     (pulse_block),
        .cpmg            (cpmg),
        .pump            (pump),
        .block           (block),
        .nutation        (nutation),
        .rx_done         (rx_done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT active output for command c, in the same form as the model table.
    function automatic logic [23:0] act(input int c);
        case (c)
            1:       act = period;
            2:       act = {8'h00, p1width};
            3:       act = {8'h00, delay};
            4:       act = {8'h00, p2width};
            5:       act = {8'h00, nut_del};
            6:       act = {16'h0000, nut_wid};
            7:       act = {21'h0, nutation, block, pump};
            8:       act = {16'h0000, pulse_block};
            9:       act = {8'h00, pulse_block_off};
            10:      act = {16'h0000, cpmg};
            default: act = 24'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 1; c <= 10; c++) begin
            exp_shadow[c] = dflt_tab[c];
            exp_active[c] = dflt_tab[c];
        end
    endtask

    task automatic model_write(input int c, input logic [23:0] v);
        logic [31:0] m;
        m = (32'd1 << wid_tab[c]) - 32'd1;
        exp_shadow[c] = v & m[23:0];
    endtask

    task automatic model_commit();
        for (int c = 1; c <= 10; c++) exp_active[c] = exp_shadow[c];
    endtask

    // Timing convention: every task starts and ends 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_frame(input int c, input logic [23:0] v, input int max_gap);
        send_byte(8'(c));
        for (int j = len_tab[c] - 1; j >= 0; j--) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            send_byte(v[j*8 +: 8]);
        end
    endtask

    // Waits (bounded) for a response, returns it and completes the handshake.
    task automatic get_resp(output logic [7:0] b, output logic e, output bit seen);
        seen     = 1'b0;
        b        = 8'h00;
        e        = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (tx_valid === 1'b1) begin
                b    = tx_byte;
                e    = err;
                seen = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        model_reset();
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got %b want 0", rx_done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        resetn = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        for (int c = 1; c <= 10; c++) begin
            n_checks++;
            if (act(c) !== exp_active[c]) begin
                n_fail++; $display("FAIL reset_default cmd%0d got %h want %h", c, act(c), exp_active[c]);
            end
        end
        n_checks++; if (tx_valid !== 1'b0 || rx_done !== 1'b0) begin n_fail++; $display("FAIL idle_quiet tx_valid %b rx_done %b want 0 0", tx_valid, rx_done); end
    endtask

    task automatic test_commit_timing();
        send_frame(2, 24'h000064, 0);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL ack_early got tx_valid %b want 0", tx_valid); end
        @(posedge clk); #1;
        n_checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h06) begin n_fail++; $display("FAIL write_ack got %b/%h want 1/06", tx_valid, tx_byte); end
        @(posedge clk); #1;
        model_write(2, 24'h000064);
        n_checks++; if (act(2) !== exp_active[2]) begin n_fail++; $display("FAIL p1w_before_commit got %0d want %0d", p1width, exp_active[2]); end
        send_byte(8'h0F);
        n_checks++; if (act(2) !== exp_active[2] || rx_done !== 1'b0) begin n_fail++; $display("FAIL commit_edge_k p1w %0d rx_done %b want %0d 0", p1width, rx_done, exp_active[2]); end
        model_commit();
        @(posedge clk); #1;
        n_checks++; if (act(2) !== exp_active[2]) begin n_fail++; $display("FAIL p1w_after_commit got %0d want %0d", p1width, exp_active[2]); end
        n_checks++; if (rx_done !== 1'b1 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL commit_k1 rx_done %b tx_valid %b want 1 0", rx_done, tx_valid); end
        @(posedge clk); #1;
        n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL rx_done_width got %b want 0", rx_done); end
        n_checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h06 || err !== 1'b0) begin n_fail++; $display("FAIL commit_ack got %b/%h err %b want 1/06 0", tx_valid, tx_byte, err); end
        @(posedge clk); #1;
    endtask

    task automatic test_period();
        logic [7:0] b; logic e; bit seen;
        send_frame(1, 24'h123456, 2);
        get_resp(b, e, seen);
        n_checks++; if (!seen || b !== 8'h06) begin n_fail++; $display("FAIL period_ack seen %b got %h want 06", seen, b); end
        model_write(1, 24'h123456);
        n_checks++; if (period !== exp_active[1]) begin n_fail++; $display("FAIL period_uncommitted got %h want %h", period, exp_active[1]); end
        send_byte(8'h0F);
        get_resp(b, e, seen);
        model_commit();
        n_checks++; if (!seen || b !== 8'h06) begin n_fail++; $display("FAIL period_commit_ack seen %b got %h want 06", seen, b); end
        n_checks++; if (period !== exp_active[1]) begin n_fail++; $display("FAIL period_committed got %h want %h", period, exp_active[1]); end
    endtask

    task automatic test_unknown();
        logic [7:0] b; logic e; bit seen;
        send_byte(8'h42);
        get_resp(b, e, seen);
        n_checks++; if (!seen || b !== 8'h15) begin n_fail++; $display("FAIL unknown_nak seen %b got %h want 15", seen, b); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL unknown_err got %b want 1", e); end
        n_checks++; if (tx_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL unknown_idle tx_valid %b err %b want 0 0", tx_valid, err); end
        send_frame(6, 24'h000005, 0);
        get_resp(b, e, seen);
        model_write(6, 24'h000005);
        n_checks++; if (!seen || b !== 8'h06 || e !== 1'b0) begin n_fail++; $display("FAIL nutw_ack got %h err %b want 06 0", b, e); end
        send_byte(8'h0F);
        get_resp(b, e, seen);
        model_commit();
        n_checks++; if (act(6) !== exp_active[6]) begin n_fail++; $display("FAIL nut_wid got %0d want %0d", nut_wid, exp_active[6]); end
    endtask

    task automatic test_timeout();
        logic [7:0] b; logic e; bit seen;
        send_byte(8'h03);
        send_byte(8'h01);
        repeat (TMO) @(posedge clk);
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early got tx_valid %b want 0", tx_valid); end
        send_byte(8'h77);
        n_checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h15) begin n_fail++; $display("FAIL timeout_nak got %b/%h want 1/15", tx_valid, tx_byte); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", err); end
        @(posedge clk); #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_byte_dropped got tx_valid %b want 0", tx_valid); end
        send_byte(8'h0F);
        get_resp(b, e, seen);
        model_commit();
        n_checks++; if (!seen || b !== 8'h06) begin n_fail++; $display("FAIL timeout_commit_ack seen %b got %h want 06", seen, b); end
        n_checks++; if (act(3) !== exp_active[3]) begin n_fail++; $display("FAIL delay_after_timeout got %0d want %0d", delay, exp_active[3]); end
    endtask

    task automatic test_hold_and_reset();
        logic [7:0] b; logic e; bit seen;
        bit got;
        tx_ready = 1'b0;
        send_frame(10, 24'h000004, 0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (tx_valid === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL hold_resp_seen got none want tx_valid"); end
        model_write(10, 24'h000004);
        for (int i = 0; i < 50; i++) begin
            rx_valid = (i % 7 == 3);
            rx_byte  = (i % 2 == 1) ? 8'h0F : 8'h01;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            n_checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h06) begin n_fail++; $display("FAIL hold_stable cyc %0d got %b/%h want 1/06", i, tx_valid, tx_byte); end
            n_checks++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL hold_drop cyc %0d rx_done %b want 0", i, rx_done); end
        end
        n_checks++; if (act(10) !== exp_active[10]) begin n_fail++; $display("FAIL cpmg_held got %0d want %0d", cpmg, exp_active[10]); end
        resetn = 1'b0;
        @(posedge clk); #1;
        model_reset();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_resp tx_valid %b want 0", tx_valid); end
        n_checks++; if (act(10) !== exp_active[10]) begin n_fail++; $display("FAIL reset_cpmg got %0d want %0d", cpmg, exp_active[10]); end
        resetn   = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h0F);
        get_resp(b, e, seen);
        model_commit();
        n_checks++; if (!seen || b !== 8'h06) begin n_fail++; $display("FAIL post_reset_commit seen %b got %h want 06", seen, b); end
        n_checks++; if (act(10) !== exp_active[10]) begin n_fail++; $display("FAIL no_partial_write cpmg %0d want %0d", cpmg, exp_active[10]); end
    endtask

    task automatic test_random_frames();
        logic [7:0] b; logic e; bit seen;
        int r, c;
        logic [23:0] v;
        logic [7:0] u;
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                c = int'($urandom_range(1, 10));
                v = 24'($urandom());
                send_frame(c, v, 3);
                get_resp(b, e, seen);
                if (len_tab[c] < 3) v = v & ((24'd1 << (8 * len_tab[c])) - 24'd1);
                model_write(c, v);
                n_checks++; if (!seen || b !== 8'h06 || e !== 1'b0) begin n_fail++; $display("FAIL rnd_write_ack it %0d cmd %0d got %h err %b want 06 0", it, c, b, e); end
                n_checks++; if (act(c) !== exp_active[c]) begin n_fail++; $display("FAIL rnd_write_no_effect it %0d cmd %0d got %h want %h", it, c, act(c), exp_active[c]); end
            end else if (r < 8) begin
                send_byte(8'h0F);
                get_resp(b, e, seen);
                model_commit();
                n_checks++; if (!seen || b !== 8'h06) begin n_fail++; $display("FAIL rnd_commit_ack it %0d got %h want 06", it, b); end
                for (int k = 1; k <= 10; k++) begin
                    n_checks++;
                    if (act(k) !== exp_active[k]) begin
                        n_fail++; $display("FAIL rnd_active it %0d cmd%0d got %h want %h", it, k, act(k), exp_active[k]);
                    end
                end
            end else begin
                do u = 8'($urandom()); while ((u >= 8'h01 && u <= 8'h0A) || u == 8'h0F);
                send_byte(u);
                get_resp(b, e, seen);
                n_checks++; if (!seen || b !== 8'h15 || e !== 1'b1) begin n_fail++; $display("FAIL rnd_unknown it %0d byte %h got %h err %b want 15 1", it, u, b, e); end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        send_byte(8'h0F);
        get_resp(b, e, seen);
        model_commit();
        for (int k = 1; k <= 10; k++) begin
            n_checks++;
            if (act(k) !== exp_active[k]) begin
                n_fail++; $display("FAIL rnd_final cmd%0d got %h want %h", k, act(k), exp_active[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_commit_timing();
        test_period();
        test_unknown();
        test_timeout();
        test_hold_and_reset();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
